// File: rtl/bitcoin_nonce_sched.sv
// Bitcoin nonce scheduler: drives one shared SHA-256 compression core through the
// midstate, second-block and outer-hash passes for a run of consecutive nonces.
module bitcoin_nonce_sched #(
  parameter int unsigned NUM_NONCES = 16,
  parameter logic [31:0] IV0 = 32'h6a09e667,
  parameter logic [31:0] IV1 = 32'hbb67ae85,
  parameter logic [31:0] IV2 = 32'h3c6ef372,
  parameter logic [31:0] IV3 = 32'ha54ff53a,
  parameter logic [31:0] IV4 = 32'h510e527f,
  parameter logic [31:0] IV5 = 32'h9b05688c,
  parameter logic [31:0] IV6 = 32'h1f83d9ab,
  parameter logic [31:0] IV7 = 32'h5be0cd19
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  output logic            busy,
  output logic            done,
  input  logic [511:0]    hdr_blk1,
  input  logic [95:0]     hdr_tail,
  input  logic [31:0]     nonce_base,
  output logic            core_start,
  output logic [7:0][31:0] core_h_init,
  output logic [7:0][31:0] core_alpha_init,
  output logic [511:0]    core_block,
  input  logic            core_done,
  input  logic [7:0][31:0] core_hash,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [31:0]     res_nonce,
  output logic [31:0]     res_h0
);

  typedef enum logic [3:0] {
    StIdle,
    StP1Go,
    StP1Wait,
    StP2Go,
    StP2Wait,
    StP3Go,
    StP3Wait,
    StEmit,
    StFin
  } state_e;

  localparam logic [7:0][31:0] Iv = {IV7, IV6, IV5, IV4, IV3, IV2, IV1, IV0};
  localparam logic [15:0] KLast = 16'(NUM_NONCES - 1);

  state_e           state_q, state_d;
  logic             armed_q;
  logic [15:0]      k_q;
  logic [15:0][31:0] blk1_q;
  logic [2:0][31:0] tail_q;
  logic [31:0]      base_q;
  logic [7:0][31:0] mid_q;
  logic [7:0][31:0] p2_hash_q;
  logic [31:0]      res_nonce_q;
  logic [31:0]      res_h0_q;

  logic             capture;
  logic             core_hit;
  logic             is_wait;
  logic             xfer;
  logic             last_nonce;
  logic [31:0]      nonce;
  logic [15:0][31:0] p2_blk;
  logic [15:0][31:0] p3_blk;

  assign nonce      = base_q + {16'h0000, k_q};
  assign is_wait    = state_q inside {StP1Wait, StP2Wait, StP3Wait};
  // armed_q is low in the first cycle of every wait state, masking a stale core_done.
  assign core_hit   = armed_q & core_done;
  assign xfer       = (state_q == StEmit) & res_ready;
  assign last_nonce = (k_q == KLast);

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StP1Go;
          capture = 1'b1;
        end
      end
      StP1Go:   state_d = StP1Wait;
      StP1Wait: if (core_hit) state_d = StP2Go;
      StP2Go:   state_d = StP2Wait;
      StP2Wait: if (core_hit) state_d = StP3Go;
      StP3Go:   state_d = StP3Wait;
      StP3Wait: if (core_hit) state_d = StEmit;
      StEmit:   if (res_ready) state_d = last_nonce ? StFin : StP2Go;
      StFin:    state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      armed_q     <= 1'b0;
      k_q         <= '0;
      blk1_q      <= '0;
      tail_q      <= '0;
      base_q      <= '0;
      mid_q       <= '0;
      p2_hash_q   <= '0;
      res_nonce_q <= '0;
      res_h0_q    <= '0;
    end else begin
      state_q <= state_d;
      armed_q <= is_wait && (state_d == state_q);
      if (capture) begin
        blk1_q <= hdr_blk1;
        tail_q <= hdr_tail;
        base_q <= nonce_base;
        k_q    <= '0;
      end else if (xfer && !last_nonce) begin
        k_q <= k_q + 16'd1;
      end
      if (state_q == StP1Wait && core_hit) mid_q <= core_hash;
      if (state_q == StP2Wait && core_hit) p2_hash_q <= core_hash;
      if (state_q == StP3Wait && core_hit) begin
        res_nonce_q <= nonce;
        res_h0_q    <= core_hash[0];
      end
    end
  end

  // Core operands are pure functions of registers that only change outside GO/WAIT.
  always_comb begin
    p2_blk      = '0;
    p2_blk[2:0] = tail_q;
    p2_blk[3]   = nonce;
    p2_blk[4]   = 32'h8000_0000;
    p2_blk[15]  = 32'h0000_0280;

    p3_blk      = '0;
    p3_blk[7:0] = p2_hash_q;
    p3_blk[8]   = 32'h8000_0000;
    p3_blk[15]  = 32'h0000_0100;

    core_h_init = Iv;
    core_block  = blk1_q;
    if (state_q inside {StP2Go, StP2Wait}) begin
      core_h_init = mid_q;
      core_block  = p2_blk;
    end else if (state_q inside {StP3Go, StP3Wait}) begin
      core_h_init = Iv;
      core_block  = p3_blk;
    end
  end

  assign core_alpha_init = core_h_init;
  assign core_start      = state_q inside {StP1Go, StP2Go, StP3Go};
  assign res_valid       = (state_q == StEmit);
  assign res_nonce       = res_nonce_q;
  assign res_h0          = res_h0_q;
  assign busy            = (state_q != StIdle);
  assign done            = (state_q == StFin);

endmodule

// File: tb/tb_bitcoin_nonce_sched.sv
// Scoreboard bench for bitcoin_nonce_sched: two instances (16 and 4 nonces) each
// driven by a behavioural SHA-256 compression core with varying latency.
module tb_bitcoin_nonce_sched;

  localparam logic [7:0][31:0] IvA = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                                      32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};

  localparam logic [31:0] ShaK [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
    32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
    32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
    32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
    32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
    32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef struct packed {
    logic [7:0][31:0]  h;
    logic [15:0][31:0] blk;
  } core_exp_t;

  typedef struct packed {
    logic [31:0] nonce;
    logic [31:0] h0;
  } res_exp_t;

  logic             clk;
  logic             reset_n;
  logic [1:0]       start;
  logic [1:0]       res_ready;
  logic [511:0]     hdr_blk1;
  logic [95:0]      hdr_tail;
  logic [31:0]      nonce_base;

  logic             busy [2];
  logic             done [2];
  logic             core_start [2];
  logic [7:0][31:0] core_h_init [2];
  logic [7:0][31:0] core_alpha_init [2];
  logic [511:0]     core_block [2];
  logic             core_done [2];
  logic [7:0][31:0] core_hash [2];
  logic             res_valid [2];
  logic [31:0]      res_nonce [2];
  logic [31:0]      res_h0 [2];

  core_exp_t cq[$];
  res_exp_t  rq[$];
  core_exp_t mon_e;
  res_exp_t  mon_r;

  int n_tests = 0;
  int n_fail  = 0;
  int cs_cnt [2] = '{0, 0};
  int done_cnt [2] = '{0, 0};

  // core model state
  logic             pend [2];
  int               cnt [2];
  int               ops [2];
  logic [7:0][31:0] stash [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    bitcoin_nonce_sched #(
      .NUM_NONCES(gi == 0 ? 16 : 4)
    ) u_dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .start          (start[gi]),
      .busy           (busy[gi]),
      .done           (done[gi]),
      .hdr_blk1       (hdr_blk1),
      .hdr_tail       (hdr_tail),
      .nonce_base     (nonce_base),
      .core_start     (core_start[gi]),
      .core_h_init    (core_h_init[gi]),
      .core_alpha_init(core_alpha_init[gi]),
      .core_block     (core_block[gi]),
      .core_done      (core_done[gi]),
      .core_hash      (core_hash[gi]),
      .res_valid      (res_valid[gi]),
      .res_ready      (res_ready[gi]),
      .res_nonce      (res_nonce[gi]),
      .res_h0         (res_h0[gi])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [7:0][31:0] sha_comp(input logic [7:0][31:0] h,
                                                input logic [7:0][31:0] a0,
                                                input logic [15:0][31:0] blk);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] s0, s1, t1, t2;
    logic [7:0][31:0] r;
    for (int t = 0; t < 16; t++) w[t] = blk[t];
    for (int t = 16; t < 64; t++) begin
      s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = w[t-16] + s0 + w[t-7] + s1;
    end
    for (int i = 0; i < 8; i++) v[i] = a0[i];
    for (int t = 0; t < 64; t++) begin
      s1 = ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25);
      t1 = v[7] + s1 + ((v[4] & v[5]) ^ (~v[4] & v[6])) + ShaK[t] + w[t];
      s0 = ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22);
      t2 = s0 + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[i] = h[i] + v[i];
    return r;
  endfunction

  task automatic check(input bit ok, input string name, input logic [511:0] act,
                       input logic [511:0] exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Queue the full expected core-operand sequence and results of one job.
  task automatic push_job(input logic [31:0] base, input int n);
    core_exp_t         e;
    res_exp_t          r;
    logic [7:0][31:0]  mid, h2, h3;
    logic [15:0][31:0] b;
    e.h = IvA; e.blk = hdr_blk1; cq.push_back(e);
    mid = sha_comp(IvA, IvA, hdr_blk1);
    for (int k = 0; k < n; k++) begin
      b = '0; b[2:0] = hdr_tail; b[3] = base + 32'(k); b[4] = 32'h80000000; b[15] = 32'h280;
      e.h = mid; e.blk = b; cq.push_back(e);
      h2 = sha_comp(mid, mid, b);
      b = '0; b[7:0] = h2; b[8] = 32'h80000000; b[15] = 32'h100;
      e.h = IvA; e.blk = b; cq.push_back(e);
      h3 = sha_comp(IvA, IvA, b);
      r.nonce = base + 32'(k); r.h0 = h3[0]; rq.push_back(r);
    end
  endtask

  // Behavioural core: done/hash stay stale through the first cycle after core_start.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int g = 0; g < 2; g++) begin
        pend[g] <= 1'b0; cnt[g] <= 0; ops[g] <= 0; stash[g] <= '0;
        core_done[g] <= 1'b0; core_hash[g] <= '0;
      end
    end else begin
      for (int g = 0; g < 2; g++) begin
        if (core_start[g]) begin
          pend[g]  <= 1'b1;
          cnt[g]   <= ops[g] % 4;
          ops[g]   <= ops[g] + 1;
          stash[g] <= sha_comp(core_h_init[g], core_alpha_init[g], core_block[g]);
        end else if (pend[g]) begin
          if (cnt[g] == 0) begin
            core_done[g] <= 1'b1; core_hash[g] <= stash[g]; pend[g] <= 1'b0;
          end else begin
            core_done[g] <= 1'b0; cnt[g] <= cnt[g] - 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      for (int g = 0; g < 2; g++) begin
        if (core_start[g]) begin
          cs_cnt[g]++;
          if (cq.size() == 0) begin
            check(1'b0, "core_start_unexpected", core_block[g], '0);
          end else begin
            mon_e = cq.pop_front();
            check(core_block[g] == mon_e.blk, "core_block", core_block[g], mon_e.blk);
            check(core_h_init[g] == mon_e.h, "core_h_init", core_h_init[g], mon_e.h);
            check(core_alpha_init[g] == mon_e.h, "core_alpha_init", core_alpha_init[g],
                  mon_e.h);
          end
        end
        if (res_valid[g] && res_ready[g]) begin
          if (rq.size() == 0) begin
            check(1'b0, "result_unexpected", res_nonce[g], '0);
          end else begin
            mon_r = rq.pop_front();
            check(res_nonce[g] == mon_r.nonce, "res_nonce", res_nonce[g], mon_r.nonce);
            check(res_h0[g] == mon_r.h0, "res_h0", res_h0[g], mon_r.h0);
          end
        end
        if (done[g]) done_cnt[g]++;
      end
    end
  end

  task automatic check_reset_outs(input int g, input string tag);
    check(busy[g] == 1'b0, {tag, "_busy"}, busy[g], 0);
    check(done[g] == 1'b0, {tag, "_done"}, done[g], 0);
    check(core_start[g] == 1'b0, {tag, "_core_start"}, core_start[g], 0);
    check(res_valid[g] == 1'b0, {tag, "_res_valid"}, res_valid[g], 0);
    check(res_nonce[g] == 32'h0, {tag, "_res_nonce"}, res_nonce[g], 0);
    check(res_h0[g] == 32'h0, {tag, "_res_h0"}, res_h0[g], 0);
  endtask

  task automatic pulse_start(input int g);
    @(posedge clk); #1 start[g] = 1'b1;
    @(posedge clk); #1 start[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, input int target, input string name);
    int n = 0;
    while (done_cnt[g] < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(done_cnt[g] == target, name, done_cnt[g], target);
  endtask

  initial begin
    logic [15:0][31:0] abc;
    logic [7:0][31:0]  abc_h;
    int c0, seen, n;

    reset_n = 1'b0; start = '0; res_ready = 2'b11; nonce_base = '0;
    for (int i = 0; i < 16; i++) hdr_blk1[i*32 +: 32] = 32'h9e3779b9 * (i + 1);
    hdr_tail = {32'h1d00ffff, 32'h12345678, 32'hcafef00d};

    // reference model sanity: SHA-256("abc")
    abc = '0; abc[0] = 32'h61626380; abc[15] = 32'h18;
    abc_h = sha_comp(IvA, IvA, abc);
    check(abc_h[0] == 32'hba7816bf, "model_sha_abc", abc_h[0], 32'hba7816bf);

    repeat (3) @(posedge clk);
    #1;
    check_reset_outs(0, "rst16");
    check_reset_outs(1, "rst4");
    reset_n = 1'b1;

    // 16 nonces from 0, always ready
    nonce_base = 32'h0;
    push_job(32'h0, 16);
    c0 = cs_cnt[0];
    pulse_start(0);
    wait_done(0, 1, "job16_done");
    check(cs_cnt[0] - c0 == 33, "job16_core_starts", cs_cnt[0] - c0, 33);
    check(rq.size() == 0, "job16_results_left", rq.size(), 0);

    // 4 nonces across the 2^32 wrap, stalled on the first result
    nonce_base = 32'hfffffffe;
    res_ready[1] = 1'b0;
    push_job(32'hfffffffe, 4);
    pulse_start(1);
    n = 0;
    do begin @(negedge clk); n++; end while (!res_valid[1] && n < 500);
    check(res_valid[1] == 1'b1, "stall_first_valid", res_valid[1], 1);
    for (int i = 0; i < 10; i++) begin
      check(res_valid[1] == 1'b1, "stall_valid", res_valid[1], 1);
      check(core_start[1] == 1'b0, "stall_no_core_start", core_start[1], 0);
      if (rq.size() > 0) begin
        check(res_nonce[1] == rq[0].nonce, "stall_nonce", res_nonce[1], rq[0].nonce);
        check(res_h0[1] == rq[0].h0, "stall_h0", res_h0[1], rq[0].h0);
      end
      @(negedge clk);
    end
    @(posedge clk); #1 res_ready[1] = 1'b1;
    wait_done(1, 1, "wrap_done");
    check(rq.size() == 0, "wrap_results_left", rq.size(), 0);

    // reset during P2_WAIT of nonce 5, then a clean rerun
    nonce_base = 32'h00001000;
    push_job(32'h00001000, 16);
    @(posedge clk); #1 start[0] = 1'b1;
    @(posedge clk); #1 start[0] = 1'b0;
    seen = 0; n = 0;
    while (seen < 12 && n < 2000) begin
      @(negedge clk);
      n++;
      if (core_start[0]) seen++;
    end
    check(seen == 12, "abort_reach_nonce5", seen, 12);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check_reset_outs(0, "abort");
    cq.delete();
    rq.delete();
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check(done_cnt[0] == 1, "abort_no_done", done_cnt[0], 1);
    push_job(32'h00001000, 16);
    c0 = cs_cnt[0];
    pulse_start(0);
    wait_done(0, 2, "rerun_done");
    check(cs_cnt[0] - c0 == 33, "rerun_core_starts", cs_cnt[0] - c0, 33);

    // start held high through a whole job, then a back-to-back job
    nonce_base = 32'h00000100;
    push_job(32'h00000100, 4);
    push_job(32'h00000100, 4);
    c0 = cs_cnt[1];
    @(posedge clk); #1 start[1] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!done[1] && n < 1000);
    check(done[1] == 1'b1, "hold_done_pulse", done[1], 1);
    check(cs_cnt[1] - c0 == 9, "hold_core_starts", cs_cnt[1] - c0, 9);
    @(negedge clk);
    check(busy[1] == 1'b0, "hold_idle_after_fin", busy[1], 0);
    @(posedge clk); #1 start[1] = 1'b0;
    @(negedge clk);
    check(busy[1] == 1'b1, "b2b_busy", busy[1], 1);
    check(core_start[1] == 1'b1, "b2b_core_start", core_start[1], 1);
    wait_done(1, 3, "b2b_done");
    repeat (20) @(negedge clk);
    check(cs_cnt[1] - c0 == 18, "b2b_core_starts", cs_cnt[1] - c0, 18);
    check(busy[1] == 1'b0, "b2b_idle", busy[1], 0);

    check(cq.size() == 0, "core_ops_left", cq.size(), 0);
    check(rq.size() == 0, "results_left", rq.size(), 0);
    check(done_cnt[0] == 2, "done_total16", done_cnt[0], 2);
    check(done_cnt[1] == 3, "done_total4", done_cnt[1], 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bitcoin_nonce_sched.md
BITCOIN_NONCE_SCHED -- requirements
Module: bitcoin_nonce_sched

Interface
REQ-001 SHALL have parameter NUM_NONCES, default 16: nonces hashed per start, legal range 1..65535.
REQ-002 SHALL have parameter IV0..IV7, defaults 6a09e667, bb67ae85, 3c6ef372, a54ff53a, 510e527f, 9b05688c, 1f83d9ab, 5be0cd19: the SHA-256 initial hash.
REQ-003 SHALL have ports: clk  in  1  clock; reset_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: start  in  1  launch job; busy  out  1  job in progress; done  out  1  one-cycle end-of-job pulse.
REQ-005 SHALL have ports: hdr_blk1  in  512  header words 0..15; hdr_tail  in  96  header words 16..18; nonce_base  in  32  first nonce.
REQ-006 SHALL have ports: core_start  out  1; core_h_init  out  32x8; core_alpha_init  out  32x8; core_block  out  512; core_done  in  1; core_hash  in  32x8.
REQ-007 SHALL have ports: res_valid  out  1; res_ready  in  1; res_nonce  out  32; res_h0  out  32.
REQ-008 SHALL treat block word t as bits [t*32 +: 32], word 0 in the LSBs, for hdr_blk1, hdr_tail and core_block.

Function
REQ-009 SHALL sequence a single shared hash core through states IDLE, P1_GO, P1_WAIT, P2_GO, P2_WAIT, P3_GO, P3_WAIT, EMIT, FIN.
REQ-010 SHALL, in IDLE with start=1, capture all job inputs, clear nonce index k to 0 and enter P1_GO; start SHALL be ignored in every other state.
REQ-011 SHALL, in each xx_GO state, drive core_start=1 for exactly one cycle with stable core_h_init, core_alpha_init and core_block, then enter xx_WAIT.
REQ-012 SHALL ignore core_done in the first cycle of each xx_WAIT state and advance on the first later cycle with core_done=1.
REQ-013 SHALL hold core_h_init, core_alpha_init and core_block constant from xx_GO through the end of xx_WAIT.
REQ-014 SHALL, in phase 1, use h_init = alpha_init = IV and block = hdr_blk1, then latch core_hash as the 256-bit midstate M once per job.
REQ-015 SHALL, in phase 2, use h_init = alpha_init = M with block words: 0..2 = hdr_tail, 3 = nonce_base+k (mod 2^32), 4 = 80000000, 5..14 = 0, 15 = 00000280.
REQ-016 SHALL, in phase 3, use h_init = alpha_init = IV with block words: 0..7 = phase-2 core_hash[0..7], 8 = 80000000, 9..14 = 0, 15 = 00000100.
REQ-017 SHALL, at EMIT entry, load res_nonce = nonce_base+k and res_h0 = phase-3 core_hash[0], and assert res_valid.
REQ-018 SHALL hold res_valid, res_nonce and res_h0 stable while res_ready=0, and complete the transfer on a cycle with res_valid=1 and res_ready=1.
REQ-019 SHALL, after a transfer, go to P2_GO with k+1 if k < NUM_NONCES-1, else to FIN.
REQ-020 SHALL NOT rerun phase 1 between nonces of a job.
REQ-021 SHALL, in FIN, pulse done=1 for one cycle and return to IDLE; busy=1 in every state except IDLE.
REQ-022 SHALL wrap the nonce modulo 2^32; for example, base FFFFFFFF with k=1 gives 00000000.
REQ-023 SHALL allow a new start in the IDLE cycle immediately following FIN.

Reset
REQ-024 SHALL, on reset_n=0, immediately enter IDLE and drive core_start=0, res_valid=0, done=0, busy=0, res_nonce=0, res_h0=0 and k=0, regardless of the current phase.
REQ-025 SHALL, after reset deasserts during a job, discard the aborted job, emit no partial results, and run the next start from phase 1.

Verification
REQ-026 SHALL be verified with NUM_NONCES=16, nonce_base=0, a behavioural core and res_ready=1 -> 16 transfers with nonces 0..15, each res_h0 matching a software double-SHA-256 of the 640-bit header, then one done pulse.
REQ-027 SHALL be verified with NUM_NONCES=4 and nonce_base=FFFFFFFE -> res_nonce sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001.
REQ-028 SHALL be verified by checking phase-2 and phase-3 core_block at each core_start -> phase-2 words 3 = nonce, 4 = 80000000, 15 = 00000280; phase-3 words 8 = 80000000, 15 = 00000100.
REQ-029 SHALL be verified with res_ready=0 for 10 cycles at the first result -> res_valid stays 1, res_nonce/res_h0 unchanged, no core_start issued; the sequence resumes after res_ready=1.
REQ-030 SHALL be verified with reset_n pulsed low during P2_WAIT of nonce 5 -> outputs at reset values within the reset cycle; a following start yields nonces from nonce_base with phase 1 rerun.
REQ-031 SHALL be verified with start held high through an entire job -> exactly one job per IDLE acceptance, with core_start issued exactly 1+2*NUM_NONCES times.
